spdif_sample_fifo: RTL and testbench

//  Sample buffer directly upstream of the SPDIF transmitter core. Accepts packed stereo

---
 rtl/spdif_sample_fifo_pkg.sv | 25 ++
 rtl/spdif_sample_fifo_if.sv | 38 +++
 rtl/spdif_fifo_ram.sv | 33 +++
 rtl/spdif_sample_fifo.sv | 105 ++++++++++
 tb/tb_spdif_sample_fifo.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/spdif_sample_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spdif_sample_fifo_pkg
// Description : Shared SPDIF sample widths, mute value and underrun counter
//               helpers used by the sample FIFO, its storage and interface.
// Revision    : 1.0 - initial release
// ============================================================================
package spdif_sample_fifo_pkg;

  localparam int SPDIF_SAMPLE_W = 32;
  localparam int SPDIF_UCNT_W   = 16;

  typedef logic [SPDIF_SAMPLE_W-1:0] sample_t;
  typedef logic [SPDIF_UCNT_W-1:0]   ucnt_t;

  // Value sent to the core while muted (underrun or after flush)
  localparam sample_t SPDIF_MUTE_SAMPLE = '0;

  // Increment the underrun counter, holding at all-ones
  function automatic ucnt_t ucnt_sat_inc(input ucnt_t c);
    return (c == '1) ? c : c + ucnt_t'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spdif_sample_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : spdif_sample_fifo_if
// Description : Bus/DMA-side push handshake, core-side sample request and
//               status signals of the SPDIF sample FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface spdif_sample_fifo_if #(
  parameter int DEPTH_W = 5
) ();
  import spdif_sample_fifo_pkg::*;

  sample_t          wr_data_i;
  logic             wr_valid_i;
  logic             wr_ready_o;
  logic             sample_req_i;
  sample_t          sample_o;
  logic [DEPTH_W:0] level_o;
  logic             low_o;
  logic             flush_i;
  logic             underrun_o;
  logic             underrun_clr_i;
  ucnt_t            underrun_count_o;

  // Producer / control side
  modport master (
    output wr_data_i, wr_valid_i, sample_req_i, flush_i, underrun_clr_i,
    input  wr_ready_o, sample_o, level_o, low_o, underrun_o, underrun_count_o
  );

  // FIFO side
  modport slave (
    input  wr_data_i, wr_valid_i, sample_req_i, flush_i, underrun_clr_i,
    output wr_ready_o, sample_o, level_o, low_o, underrun_o, underrun_count_o
  );

endinterface
`default_nettype wire

// File: rtl/spdif_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : spdif_fifo_ram
// Description : 2**ADDR_W x sample storage, synchronous write, asynchronous
//               read. No reset: contents are only meaningful between pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module spdif_fifo_ram
  import spdif_sample_fifo_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  wire logic              clk_i,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire sample_t           wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output sample_t                rdata
);

  sample_t mem [0:(1<<ADDR_W)-1];

  // Store the pushed sample at the write pointer
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/spdif_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spdif_sample_fifo
// Description : Sample buffer in front of the SPDIF transmitter core. Pushes
//               from the bus side, pops on the core's sample request, mutes
//               and counts underruns.
// Revision    : 1.0 - initial release
// ============================================================================
module spdif_sample_fifo
  import spdif_sample_fifo_pkg::*;
#(
  parameter int DEPTH_W    = 5,
  parameter int LOW_THRESH = 8
) (
  input  wire logic            clk_i,
  input  wire logic            rst_i,
  spdif_sample_fifo_if.slave   bus
);

  localparam logic [DEPTH_W:0] DEPTH   = (DEPTH_W+1)'(2**DEPTH_W);
  localparam logic [DEPTH_W:0] LOW_LVL = (DEPTH_W+1)'(LOW_THRESH);

  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic [DEPTH_W:0]   level;
  sample_t            sample_q;
  sample_t            ram_rdata;
  logic               underrun_q;
  ucnt_t              ucnt_q;
  logic               full;
  logic               empty;
  logic               do_push;
  logic               do_pop;
  logic               do_under;

  assign full  = (level == DEPTH);
  assign empty = (level == '0);

  // Flush dominates; a request on an empty FIFO is never served by a same-cycle push
  assign do_push  = bus.wr_valid_i   && !full  && !bus.flush_i;
  assign do_pop   = bus.sample_req_i && !empty && !bus.flush_i;
  assign do_under = bus.sample_req_i &&  empty && !bus.flush_i;

  spdif_fifo_ram #(
    .ADDR_W (DEPTH_W)
  ) u_ram (
    .clk_i (clk_i),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (bus.wr_data_i),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_W'(1);
      level <= level + (DEPTH_W+1)'(do_push) - (DEPTH_W+1)'(do_pop);
    end
  end

  // Output sample register: next entry on a pop, mute on underrun or flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sample_q <= SPDIF_MUTE_SAMPLE;
    end else if (bus.flush_i || do_under) begin
      sample_q <= SPDIF_MUTE_SAMPLE;
    end else if (do_pop) begin
      sample_q <= ram_rdata;
    end
  end

  // Sticky underrun flag and saturating count; a new underrun beats a clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else if (do_under) begin
      underrun_q <= 1'b1;
      ucnt_q     <= bus.underrun_clr_i ? ucnt_t'(1) : ucnt_sat_inc(ucnt_q);
    end else if (bus.underrun_clr_i) begin
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end
  end

  assign bus.wr_ready_o       = !full;
  assign bus.low_o            = (level <= LOW_LVL);
  assign bus.level_o          = level;
  assign bus.sample_o         = sample_q;
  assign bus.underrun_o       = underrun_q;
  assign bus.underrun_count_o = ucnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spdif_sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_spdif_sample_fifo
// Description : Scoreboard bench for spdif_sample_fifo with a queue-based
//               reference model and a decoupled sample monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spdif_sample_fifo;

  localparam int DW  = 5;
  localparam int DEP = 32;
  localparam int LOW = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  spdif_sample_fifo_if #(.DEPTH_W(DW)) bus ();

  spdif_sample_fifo #(
    .DEPTH_W    (DW),
    .LOW_THRESH (LOW)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents, underrun state, expected samples
  logic [31:0] mdl[$];
  logic [31:0] exp_q[$];
  bit          m_uf;
  int          m_uc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("level", 32'(bus.level_o), 32'(mdl.size()));
    chk("wr_ready", 32'(bus.wr_ready_o), 32'(mdl.size() != DEP));
    chk("low", 32'(bus.low_o), 32'(mdl.size() <= LOW));
    chk("underrun", 32'(bus.underrun_o), 32'(m_uf));
    chk("underrun_count", 32'(bus.underrun_count_o), 32'(m_uc));
  endtask

  // One clock of stimulus, with the model advanced by the same inputs
  task automatic step(input bit push, input logic [31:0] d, input bit req,
                      input bit fl, input bit clr, input bit do_chk);
    int sz;
    bit und;
    @(negedge clk_i);
    bus.wr_valid_i     = push;
    bus.wr_data_i      = d;
    bus.sample_req_i   = req;
    bus.flush_i        = fl;
    bus.underrun_clr_i = clr;
    sz  = mdl.size();
    und = 1'b0;
    if (fl) begin
      mdl.delete();
      exp_q.push_back(32'h0);
      if (clr) begin m_uf = 1'b0; m_uc = 0; end
    end else begin
      if (req) begin
        if (sz != 0) exp_q.push_back(mdl.pop_front());
        else begin exp_q.push_back(32'h0); und = 1'b1; end
      end
      if (push && sz != DEP) mdl.push_back(d);
      if (und) begin
        m_uf = 1'b1;
        m_uc = clr ? 1 : ((m_uc == 65535) ? 65535 : m_uc + 1);
      end else if (clr) begin
        m_uf = 1'b0;
        m_uc = 0;
      end
    end
    @(posedge clk_i);
    #1;
    if (do_chk) check_state();
  endtask

  // Asynchronous reset applied between edges; outputs checked before any clock
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    bus.wr_valid_i     = 1'b0;
    bus.sample_req_i   = 1'b0;
    bus.flush_i        = 1'b0;
    bus.underrun_clr_i = 1'b0;
    #1;
    mdl.delete();
    m_uf = 1'b0;
    m_uc = 0;
    chk("rst_pending", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    chk("rst_sample", bus.sample_o, 32'h0);
    check_state();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Monitor: every request (or flush) gives a new sample_o one edge later
  initial begin
    bit pend;
    forever begin
      @(posedge clk_i);
      pend = (bus.sample_req_i || bus.flush_i) && !rst_i;
      #1;
      if (pend) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", 32'h1, 32'h0);
        else chk("sample", bus.sample_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.wr_data_i      = '0;
    bus.wr_valid_i     = 1'b0;
    bus.sample_req_i   = 1'b0;
    bus.flush_i        = 1'b0;
    bus.underrun_clr_i = 1'b0;
    m_uf = 1'b0;
    m_uc = 0;
    do_reset();

    // 1: three pushes, no requests
    step(1, 32'hAAAA_0001, 0, 0, 0, 1);
    step(1, 32'hBBBB_0002, 0, 0, 0, 1);
    step(1, 32'hCCCC_0003, 0, 0, 0, 1);
    chk("t1_sample_idle", bus.sample_o, 32'h0);
    repeat (3) step(0, 0, 1, 0, 0, 1);

    // 2: fill to full, dropped extra push, pop at full, drain in order
    for (int i = 0; i < DEP; i++) step(1, 32'(i), 0, 0, 0, 1);
    step(1, 32'hDEAD_BEEF, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < DEP - 1; i++) step(0, 0, 1, 0, 0, 1);

    // 3: underrun with same-cycle push, then the pushed word comes out
    step(1, 32'h1234_5678, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);

    // 4: saturate the underrun counter, then clear races
    for (int i = 0; i < 70000; i++) step(0, 0, 1, 0, 0, 0);
    check_state();
    step(0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);

    // 5: flush at level 5 with push and request in the same cycle
    for (int i = 0; i < 5; i++) step(1, 32'h5000 + 32'(i), 0, 0, 0, 1);
    step(1, 32'hFFFF_0000, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // 6: producer faster than consumer, reset mid-stream, then resume
    for (int c = 0; c < 400; c++)
      step($urandom_range(0, 3) != 0, $urandom, (c % 8) == 7, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, $urandom, 0, 0, 0, 1);
    for (int c = 0; c < 600; c++)
      step($urandom_range(0, 3) != 0, $urandom, (c % 8) == 0, 0, 0, 1);
    chk("t6_no_underrun", 32'(bus.underrun_o), 32'h0);
    step(0, 0, 0, 0, 0, 1);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
